// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared types and arithmetic helpers for the partial-sum accumulator
package psum_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_OUT} state_e;
  localparam int LANES = 4;
  localparam int MAX_W = 128;
  function automatic int psum_w(input int col_width);
    return col_width * LANES;
  endfunction
  // Returns {clamped, value}: a+b clamped to the signed range of w bits (w < MAX_W).
  function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] a,
                                             input logic signed [MAX_W-1:0] b,
                                             input int unsigned w);
    logic signed [MAX_W-1:0] s, hi, lo;
    s  = a + b;
    hi = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    lo = ~hi;
    return s > hi ? {1'b1, hi} : s < lo ? {1'b1, lo} : {1'b0, s};
  endfunction
endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add: one column of sign-extend, add and clamp with a clamp flag
module psum_sat_add
  import psum_acc_pkg::*;
#(
  parameter int PSUM_W = 52,
  parameter int ACC_W  = 64
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  sum,
  output logic              clamp
);
  logic [MAX_W:0] r;
  logic           unused_hi;
  // Widen both operands to the package width so the add itself cannot wrap
  always_comb begin
    r         = sat_add({{(MAX_W-ACC_W){acc[ACC_W-1]}}, acc},
                        {{(MAX_W-PSUM_W){psum[PSUM_W-1]}}, psum}, ACC_W);
    sum       = r[ACC_W-1:0];
    clamp     = r[MAX_W];
    unused_hi = ^r[MAX_W-1:ACC_W];
  end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: multi-pass column partial-sum accumulator with a double-buffered valid/ready result
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int COL_WIDTH  = 13,
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [7:0]                       pass_count,
  input  logic                             psum_valid,
  input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0] psums,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic [ARRAY_SIZE-1:0]            out_sat,
  output logic                             overrun
);
  localparam int PW = psum_w(COL_WIDTH);
  localparam int VW = ARRAY_SIZE * ACC_WIDTH;
  state_e               state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic [VW-1:0]        acc_q, acc_d, sum, out_data_q, out_data_d;
  logic [ARRAY_SIZE-1:0] sat_q, sat_d, clamp, out_sat_q, out_sat_d;
  logic                 out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                 out_free, take, last, start_ok, transfer;
  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
    psum_sat_add #(.PSUM_W(PW), .ACC_W(ACC_WIDTH)) u_add (
      .acc   (acc_q[c*ACC_WIDTH +: ACC_WIDTH]),
      .psum  (psums[c*PW +: PW]),
      .sum   (sum[c*ACC_WIDTH +: ACC_WIDTH]),
      .clamp (clamp[c])
    );
  end
  // Control strobes shared by the FSM and the datapath
  always_comb begin
    out_free = !out_valid_q || out_ready;
    take     = state_q == ACCUM && psum_valid;
    last     = take && rem_q == 8'd1;
    start_ok = state_q == IDLE && start && pass_count != 8'd0;
    transfer = state_q == WAIT_OUT && out_free;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // Next state: a final vector with a busy output register parks the result in WAIT_OUT
  always_comb
    state_d = start_ok ? ACCUM :
              last     ? (out_free ? IDLE : WAIT_OUT) :
              transfer ? IDLE : state_q;
  // FSM outputs
  always_comb busy = state_q != IDLE;
  // Datapath next values: accumulator bank, pass counter, output register, overrun
  always_comb begin
    rem_d       = start_ok ? pass_count : take ? rem_q - 8'd1 : rem_q;
    acc_d       = start_ok ? '0 : take ? sum : acc_q;
    sat_d       = start_ok ? '0 : take ? sat_q | clamp : sat_q;
    out_valid_d = (last && out_free) || transfer ? 1'b1 : out_valid_q && !out_ready;
    out_data_d  = last && out_free ? sum : transfer ? acc_q : out_data_q;
    out_sat_d   = last && out_free ? sat_q | clamp : transfer ? sat_q : out_sat_q;
    overrun_d   = state_q == WAIT_OUT && psum_valid;
  end
  // Datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q       <= '0;
      acc_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      overrun_q   <= overrun_d;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign overrun   = overrun_q;
endmodule
